// File: rtl/display_scan_controller.sv
// Drives four common-anode MM:SS digits from one shared 7-segment decoder.
// A guard interval separates digits, and the displayed digits/error only change between frames.
module display_scan_controller #(
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        error_in,
  input  logic        lz_en,
  output logic [3:0]  data,
  output logic [3:0]  select_n,
  output logic        frame_done,
  output logic        invalid
);

  localparam int MAX_CYCLES = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   index_reg, index_next;
  logic [CW-1:0] count_reg, count_next;
  logic [15:0]  pending_digits_reg;
  logic         pending_error_reg;
  logic [15:0]  active_digits_reg, active_digits_next;
  logic         active_error_reg, active_error_next;
  logic         boundary;
  logic [3:0]   digit_over;
  logic         err_mode_next;
  logic         blank_next;
  logic [3:0]   code_next;
  logic [3:0]   select_next;

  always_comb begin
    state_next         = state_reg;
    index_next         = index_reg;
    count_next         = count_reg + CW'(1);
    boundary           = 1'b0;
    active_digits_next = active_digits_reg;
    active_error_next  = active_error_reg;
    if (!enable) begin
      // Held dark; the active buffer tracks pending so a restart shows fresh data.
      state_next         = GUARD;
      index_next         = 2'd0;
      count_next         = '0;
      active_digits_next = pending_digits_reg;
      active_error_next  = pending_error_reg;
    end else begin
      case (state_reg)
        GUARD: begin
          if (count_reg == CW'(GUARD_CYCLES - 1)) begin
            state_next = DRIVE;
            count_next = '0;
          end
        end
        DRIVE: begin
          if (count_reg == CW'(SCAN_DIV - 1)) begin
            state_next = GUARD;
            count_next = '0;
            index_next = index_reg + 2'd1;
            if (index_reg == 2'd3) begin
              boundary           = 1'b1;
              active_digits_next = pending_digits_reg;
              active_error_next  = pending_error_reg;
            end
          end
        end
        default: begin
          state_next = GUARD;
          count_next = '0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_over
      assign digit_over[gi] = (active_digits_next[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign err_mode_next = active_error_next | (|digit_over);
  assign blank_next    = lz_en & ~err_mode_next & (active_digits_next[15:12] == 4'd0);

  always_comb begin
    code_next = active_digits_next[{index_next, 2'b00} +: 4];
    if (err_mode_next) begin
      case (index_next)
        2'd3:    code_next = 4'b1100;
        2'd0:    code_next = 4'b1111;
        default: code_next = 4'b1110;
      endcase
    end
  end

  // Outputs are computed from next-state values so they register on the same edge as the FSM.
  always_comb begin
    select_next = 4'b1111;
    if (state_next == DRIVE && !(index_next == 2'd3 && blank_next)) begin
      select_next[index_next] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= GUARD;
      index_reg          <= 2'd0;
      count_reg          <= '0;
      pending_digits_reg <= 16'd0;
      pending_error_reg  <= 1'b0;
      active_digits_reg  <= 16'd0;
      active_error_reg   <= 1'b0;
      data               <= 4'd0;
      select_n           <= 4'b1111;
      frame_done         <= 1'b0;
      invalid            <= 1'b0;
    end else begin
      state_reg         <= state_next;
      index_reg         <= index_next;
      count_reg         <= count_next;
      active_digits_reg <= active_digits_next;
      active_error_reg  <= active_error_next;
      if (load) begin
        pending_digits_reg <= digits_in;
        pending_error_reg  <= error_in;
      end
      data       <= code_next;
      select_n   <= select_next;
      frame_done <= boundary;
      invalid    <= ~active_error_next & (|digit_over);
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with SCAN_DIV=4, GUARD_CYCLES=2 (24-cycle frames).
module tb_display_scan_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'd0;
  logic        error_in = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  data;
  logic [3:0]  select_n;
  logic        frame_done;
  logic        invalid;

  int checks = 0;
  int errors = 0;

  display_scan_controller #(.SCAN_DIV(4), .GUARD_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load(load),
    .digits_in(digits_in), .error_in(error_in), .lz_en(lz_en),
    .data(data), .select_n(select_n), .frame_done(frame_done), .invalid(invalid)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] digits;
    logic        err;
    logic        lz;
    logic [15:0] codes;   // expected decoder code per index, same layout as digits
    logic        blank;   // index 3 expected dark during DRIVE
    logic        inv;
  } rec_t;

  rec_t vec [6];
  rec_t rst_rec;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_wait actual=no_frame_done required=frame_done t=%0t", $time);
    end
  endtask

  // Checks one full frame cycle by cycle, optionally loading new data mid-frame.
  task automatic check_frame(input rec_t exp, input bit do_load, input rec_t ld);
    bit ok;
    int d;
    int p;
    logic [3:0] exp_sel;
    logic [3:0] exp_data;
    wait_frame(ok);
    if (!ok) return;
    lz_en = exp.lz;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clock);
      d = k / 6;
      p = k % 6;
      exp_data = exp.codes[4*d +: 4];
      if (p < 2 || (d == 3 && exp.blank)) exp_sel = 4'b1111;
      else exp_sel = ~(4'b0001 << d);
      check($sformatf("select_n k=%0d", k), {12'd0, select_n}, {12'd0, exp_sel});
      check($sformatf("data k=%0d", k), {12'd0, data}, {12'd0, exp_data});
      check($sformatf("frame_done k=%0d", k), {15'd0, frame_done}, {15'd0, (k == 0)});
      check($sformatf("invalid k=%0d", k), {15'd0, invalid}, {15'd0, exp.inv});
      if (do_load && k == 10) begin
        digits_in = ld.digits;
        error_in  = ld.err;
        load      = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    $display("frame digits=%h err=%0d lz=%0d checked, errors so far %0d", exp.digits, exp.err, exp.lz, errors);
  endtask

  initial begin
    bit ok;
    bit early;
    rst_rec = '{digits: 16'h0000, err: 1'b0, lz: 1'b0, codes: 16'h0000, blank: 1'b0, inv: 1'b0};
    vec[0] = '{digits: 16'h1234, err: 1'b0, lz: 1'b0, codes: 16'h1234, blank: 1'b0, inv: 1'b0};
    vec[1] = '{digits: 16'h1234, err: 1'b1, lz: 1'b0, codes: 16'hCEEF, blank: 1'b0, inv: 1'b0};
    vec[2] = '{digits: 16'h12A4, err: 1'b0, lz: 1'b0, codes: 16'hCEEF, blank: 1'b0, inv: 1'b1};
    vec[3] = '{digits: 16'h0059, err: 1'b0, lz: 1'b0, codes: 16'h0059, blank: 1'b0, inv: 1'b0};
    vec[4] = '{digits: 16'h0559, err: 1'b0, lz: 1'b1, codes: 16'h0559, blank: 1'b1, inv: 1'b0};
    vec[5] = '{digits: 16'h0559, err: 1'b1, lz: 1'b1, codes: 16'hCEEF, blank: 1'b0, inv: 1'b0};

    // Reset state
    @(negedge clock);
    check("rst select_n", {12'd0, select_n}, 16'h000F);
    check("rst data", {12'd0, data}, 16'h0000);
    check("rst frame_done", {15'd0, frame_done}, 16'h0000);
    check("rst invalid", {15'd0, invalid}, 16'h0000);
    $display("reset state checked");
    @(negedge clock);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Each frame shows the previous record while the next one is loaded mid-frame.
    for (int i = 0; i <= 6; i++) begin
      check_frame((i == 0) ? rst_rec : vec[i-1], (i < 6), (i < 6) ? vec[i] : rst_rec);
    end
    lz_en = 1'b0;

    // Disable during index-2 DRIVE, load while dark, then re-enable.
    wait_frame(ok);
    if (ok) begin
      for (int k = 1; k <= 14; k++) @(negedge clock);
      check("pre-disable select_n", {12'd0, select_n}, 16'h000B);
      enable = 1'b0;
      @(negedge clock);
      check("disable select_n", {12'd0, select_n}, 16'h000F);
      check("disable frame_done", {15'd0, frame_done}, 16'h0000);
      digits_in = 16'h4321;
      error_in  = 1'b0;
      load      = 1'b1;
      @(negedge clock);
      load = 1'b0;
      @(negedge clock);
      check("dark data", {12'd0, data}, 16'h0001);
      check("dark select_n", {12'd0, select_n}, 16'h000F);
      check("dark invalid", {15'd0, invalid}, 16'h0000);
      $display("disable sequence checked");
      enable = 1'b1;
      early = 1'b0;
      for (int n = 1; n <= 24; n++) begin
        @(negedge clock);
        if (n == 1) check("reenable guard select_n", {12'd0, select_n}, 16'h000F);
        if (n == 2) begin
          check("reenable drive select_n", {12'd0, select_n}, 16'h000E);
          check("reenable drive data", {12'd0, data}, 16'h0001);
        end
        if (n < 24 && frame_done === 1'b1) early = 1'b1;
        if (n == 24) check("reenable frame_done at 24", {15'd0, frame_done}, 16'h0001);
      end
      check("reenable no early frame_done", {15'd0, early}, 16'h0000);
      $display("reenable sequence checked");
    end

    // Asynchronous reset in the middle of a DRIVE phase.
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (select_n !== 4'b1111) begin
        ok = 1'b1;
        break;
      end
    end
    check("drive before reset seen", {15'd0, ok}, 16'h0001);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst select_n", {12'd0, select_n}, 16'h000F);
    check("async rst data", {12'd0, data}, 16'h0000);
    check("async rst invalid", {15'd0, invalid}, 16'h0000);
    $display("async reset checked");
    @(negedge clock);
    reset_n = 1'b1;
    check_frame(rst_rec, 1'b0, rst_rec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes one shared 7-segment decoder across four common-anode digits (MM:SS) of the irrigation timer display.
- Double-buffers the four BCD digits and an error flag. Sequences decoder input and digit enables with an anti-ghosting guard interval.
- Substitutes the "Erro" codes when an error is flagged or a digit is out of range.
- Sits between the timer counter/FSM and the display decoder: data drives the decoder input, select_n drives the anode drivers.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit is driven (DRIVE phase); must be ≥1.
- GUARD_CYCLES, 16: clock cycles with all digits off before each digit (GUARD phase); must be ≥1.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scanning; 0 = display dark and FSM held.
- load  input  1  1-cycle strobe; captures digits_in/error_in into the pending buffer.
- digits_in  input  16  BCD digits; [15:12] leftmost (index 3) … [3:0] rightmost (index 0).
- error_in  input  1  request "Erro" display.
- lz_en  input  1  leading-zero suppression for digit index 3.
- data  output  4  code to the display decoder.
- select_n  output  4  active-low digit enables; bit i = digit index i.
- frame_done  output  1  1-cycle pulse at the end of each full 4-digit frame.
- invalid  output  1  active frame contains a BCD digit >9 while error is not flagged.

Behaviour:
- Reset: select_n=4'b1111, data=4'b0000, frame_done=0, invalid=0. Pending and active buffers are cleared (digits 0, error 0). digit index=0, cycle counter=0, state=GUARD. Reset is asserted asynchronously and released synchronously to clock.
- Registers: pending{digits,error} and active{digits,error}.
  - load=1 at a rising edge writes pending.
  - active<=pending only at a frame boundary. A load on the boundary edge lands in pending and takes effect the next frame, so the displayed frame never tears.
- FSM (two states, one cycle counter):
  - GUARD: select_n=4'b1111 and data=code(index). Stays GUARD_CYCLES cycles, then goes to DRIVE with counter cleared.
  - DRIVE: select_n[index]=0, others 1, data held. Stays SCAN_DIV cycles, then goes to GUARD with index=(index+1) mod 4.
  - Frame boundary: the DRIVE exit with index=3. Index wraps to 0, frame_done=1 for exactly that next cycle, and active<=pending on the same edge.
  - Frame period = 4*(GUARD_CYCLES+SCAN_DIV) cycles.
- All outputs are registered. data and select_n change only on clock edges, and data never changes while any select_n bit is 0.
- Code selection, code(i):
  - Error mode: active.error=1, or any active digit >9. Codes are index3=4'b1100 (E), index2=4'b1110 (r), index1=4'b1110 (r), index0=4'b1111 (o).
  - Normal mode: code(i)=active.digits[4i+3:4i].
  - invalid=1 iff active.error=0 and any active digit >9. It updates with active.
- Leading-zero suppression: when lz_en=1, normal mode, and active digit3==0, select_n[3] stays 1 during index-3 DRIVE. Timing and data are unchanged. Error mode is never suppressed.
- enable=0, sampled every edge, in any state:
  - Next edge: select_n=4'b1111, state=GUARD, index=0, counter=0, frame_done=0.
  - Loads are still accepted into pending, and active<=pending every cycle while disabled.
  - When enable rises, scanning restarts from a full GUARD for index 0.
- enable toggling or reset mid-DRIVE is legal. The digit is cut off immediately on the next edge (or asynchronously for reset), with no partial frame_done.
- The counter width is sized for max(SCAN_DIV,GUARD_CYCLES)-1. The terminal count compares equal to N-1, so there is no off-by-one.

Test Plan (SCAN_DIV=4, GUARD_CYCLES=2, frame=24 cycles):
- Reset, enable=1, load digits_in=16'h1234 → from the second frame, sequence per digit is 2 cycles select_n=1111, then 4 cycles select_n=1110 data=4; repeats for 1101/3, 1011/2, 0111/1. frame_done pulses once every 24 cycles.
- load error_in=1 mid-frame → current frame finishes with 1234. Next frame shows data 1111,1110,1110,1100 on indices 0..3; invalid=0.
- load digits_in=16'h12A4, error_in=0 → next frame is the "Erro" pattern with invalid=1. A subsequent load of 16'h0059 → normal display, invalid=0 after the boundary.
- lz_en=1, digits_in=16'h0559 → index-3 DRIVE keeps select_n=1111, and frame length stays 24 cycles. Set error_in=1 → index 3 is driven with 1100.
- Deassert enable during index-2 DRIVE → select_n=1111 next edge. Reassert → 2 GUARD cycles, then index 0 driven; no frame_done until 24 cycles later.
- Assert reset_n=0 asynchronously mid-DRIVE → select_n=1111 and data=0 immediately. After release, active digits are 0000 until a load plus frame boundary.
